demux_scheduler: RTL

//  Buffers 4-bit words from one upstream source and schedules them onto the
//  1:4 output demux by driving its select and enable. Each cycle it issues at

---
 rtl/demux_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/demux_scheduler.sv
// ============================================================================
// Module  : demux_scheduler
// Brief   : Buffers tagged 4-bit words and issues one per cycle to a 1:4 demux.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_scheduler #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_data,
   input  logic [1:0]               in_dest,
   input  logic                     mode,
   input  logic [3:0]               out_ready,
   output logic [1:0]               sel,
   output logic                     enable,
   output logic [3:0]               out_data,
   output logic [3:0]               out_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);

   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]    sel_q, sel_d;
   logic          enable_q, enable_d;
   logic [3:0]    out_data_q, out_data_d;
   logic [3:0]    out_valid_q, out_valid_d;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_issue;
   logic [1:0]    w_tgt;
   logic [1:0]    w_rr_tgt;
   logic          w_rr_found;
   logic [1:0]    w_idx;
   logic [1:0]    w_head_dest;
   logic [3:0]    w_head_data;

   assign w_full      = (count_q == C_FULL_CNT);
   assign w_empty     = (count_q == '0);
   assign in_ready    = !w_full && !reset;
   assign w_push      = in_valid && in_ready;
   assign w_head_dest = mem_q[rd_ptr_q][5:4];
   assign w_head_data = mem_q[rd_ptr_q][3:0];

   // Round-robin: first ready channel starting at rr_ptr, wrapping mod 4.
   always_comb begin
      w_rr_tgt   = rr_ptr_q;
      w_rr_found = 1'b0;
      w_idx      = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         w_idx = rr_ptr_q + 2'(k);
         if (!w_rr_found && out_ready[w_idx]) begin
            w_rr_tgt   = w_idx;
            w_rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      if (mode) begin
         w_tgt   = w_rr_tgt;
         w_issue = !w_empty && w_rr_found;
      end else begin
         w_tgt   = w_head_dest;
         w_issue = !w_empty && out_ready[w_head_dest];
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rr_ptr_d    = rr_ptr_q;
      sel_d       = sel_q;
      enable_d    = 1'b0;
      out_data_d  = 4'd0;
      out_valid_d = 4'd0;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_issue) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         sel_d       = w_tgt;
         enable_d    = 1'b1;
         out_data_d  = w_head_data;
         out_valid_d = 4'b0001 << w_tgt;
         if (mode) begin
            rr_ptr_d = w_tgt + 2'd1;
         end
      end
      case ({w_push, w_issue})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; in_ready is low during reset so nothing lands.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {in_dest, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rr_ptr_q    <= 2'd0;
         sel_q       <= 2'd0;
         enable_q    <= 1'b0;
         out_data_q  <= 4'd0;
         out_valid_q <= 4'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rr_ptr_q    <= rr_ptr_d;
         sel_q       <= sel_d;
         enable_q    <= enable_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sel       = sel_q;
   assign enable    = enable_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign count     = count_q;

endmodule

`default_nettype wire
